// File: rtl/pdu_input_filter.sv
// Button/switch conditioning for the PDU: 2-flop sync, per-channel debounce,
// edge pulses and optional auto-repeat press pulses for held buttons.
//
// state   | meaning
// STABLE  | s2 == db_out, db_cnt held at 0
// PENDING | s2 != db_out, db_cnt counts toward terminal count
module pdu_input_filter #(
   parameter int                N_CH       = 8,
   parameter int                CNT_W      = 20,
   parameter int                DB_CNT     = 1000000,
   parameter logic [N_CH-1:0]   REP_MASK   = N_CH'(8'b0000_0010),
   parameter int                REP_DELAY  = 50000000,
   parameter int                REP_PERIOD = 10000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] db_out,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic [N_CH-1:0] press
);

   localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

   if (DB_CNT < 1 || longint'(DB_CNT) > CNT_MAX) begin : g_bad_db_cnt
      $error("pdu_input_filter: DB_CNT out of range for CNT_W");
   end
   if (REP_DELAY < 1 || longint'(REP_DELAY) > CNT_MAX) begin : g_bad_rep_delay
      $error("pdu_input_filter: REP_DELAY out of range for CNT_W");
   end
   if (REP_PERIOD < 1 || longint'(REP_PERIOD) > CNT_MAX) begin : g_bad_rep_period
      $error("pdu_input_filter: REP_PERIOD out of range for CNT_W");
   end
   if (REP_PERIOD > REP_DELAY) begin : g_bad_rep_order
      $error("pdu_input_filter: REP_PERIOD must not exceed REP_DELAY");
   end

   localparam logic [CNT_W-1:0] DB_TC      = CNT_W'(DB_CNT - 1);
   localparam logic [CNT_W-1:0] REP_TC     = CNT_W'(REP_DELAY - 1);
   localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REP_DELAY - REP_PERIOD);

   logic [N_CH-1:0] s1;
   logic [N_CH-1:0] s2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw_in;
         s2 <= s1;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic             db_q;
      logic             rise_q;
      logic             fall_q;
      logic [CNT_W-1:0] db_cnt;
      logic             accept;

      assign accept = (s2[i] != db_q) && (db_cnt == DB_TC);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            db_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            db_cnt <= '0;
         end else begin
            rise_q <= accept && s2[i];
            fall_q <= accept && !s2[i];
            if (s2[i] == db_q) begin
               db_cnt <= '0;
            end else if (accept) begin
               db_q   <= s2[i];
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end
      end

      assign db_out[i] = db_q;
      assign rise[i]   = rise_q;
      assign fall[i]   = fall_q;

      if (REP_MASK[i]) begin : g_rep
         logic [CNT_W-1:0] rep_cnt;
         logic             rep_q;

         // accept while high is a fall: clearing here keeps a repeat from landing on it
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rep_cnt <= '0;
               rep_q   <= 1'b0;
            end else if (!db_q || accept) begin
               rep_cnt <= '0;
               rep_q   <= 1'b0;
            end else if (rep_cnt == REP_TC) begin
               rep_cnt <= REP_RELOAD;
               rep_q   <= 1'b1;
            end else begin
               rep_cnt <= rep_cnt + 1'b1;
               rep_q   <= 1'b0;
            end
         end

         assign press[i] = rise_q | rep_q;
      end else begin : g_no_rep
         assign press[i] = rise_q;
      end
   end

endmodule

// File: tb/tb_pdu_input_filter.sv
// Directed bench for pdu_input_filter: a sliding-window model of the debounce
// plus an edge-time model of auto-repeat, compared every cycle, and literal pins.
module tb_pdu_input_filter;

   localparam int N_CH = 8;
   localparam int DBC  = 4;
   localparam logic [7:0] REP = 8'h02;
   localparam int RD   = 10;
   localparam int RP   = 3;

   logic       clk;
   logic       rst;
   logic [7:0] raw_in;
   logic [7:0] db_out;
   logic [7:0] rise;
   logic [7:0] fall;
   logic [7:0] press;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   pdu_input_filter #(
      .N_CH       (N_CH),
      .CNT_W      (8),
      .DB_CNT     (DBC),
      .REP_MASK   (REP),
      .REP_DELAY  (RD),
      .REP_PERIOD (RP)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .raw_in (raw_in),
      .db_out (db_out),
      .rise   (rise),
      .fall   (fall),
      .press  (press)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // model: raw samples per edge; s2 seen at edge n is raw from edge n-2
   logic [7:0] hist[$];
   logic [7:0] m_db, m_rise, m_fall, m_press;
   int         m_r_edge[8];
   int         cyc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         hist.delete();
         m_db = '0; m_rise = '0; m_fall = '0; m_press = '0;
         cyc = 0;
         for (int c = 0; c < 8; c++) m_r_edge[c] = 0;
      end else begin
         cyc++;
         hist.push_back(raw_in);
         if (hist.size() > 16) void'(hist.pop_front());
         for (int c = 0; c < 8; c++) begin
            bit   flip;
            int   idx;
            int   d;
            logic v;
            flip = 1'b1;
            for (int j = 2; j <= DBC + 1; j++) begin
               idx = hist.size() - 1 - j;
               v = (idx >= 0) ? hist[idx][c] : 1'b0;
               if (v == m_db[c]) flip = 1'b0;
            end
            m_rise[c] = flip && !m_db[c];
            m_fall[c] = flip && m_db[c];
            if (flip) m_db[c] = !m_db[c];
            if (m_rise[c]) m_r_edge[c] = cyc;
            d = cyc - m_r_edge[c];
            m_press[c] = m_rise[c] |
                         (REP[c] && m_db[c] && d >= RD && ((d - RD) % RP) == 0);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("db_out", {24'd0, db_out}, {24'd0, m_db});
         chk("rise",   {24'd0, rise},   {24'd0, m_rise});
         chk("fall",   {24'd0, fall},   {24'd0, m_fall});
         chk("press",  {24'd0, press},  {24'd0, m_press});
         chk("rise_fall_excl", {24'd0, rise & fall}, 32'd0);
      end
   end

   initial begin
      raw_in = '0;
      rst    = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("reset_outputs", {db_out, rise, fall, press}, 32'd0);
      cycles(3);
      rst = 1'b0;
      cycles(10);

      // 1: clean press and release on ch0
      raw_in[0] = 1'b1;
      cycles(5);
      chk("t1_db_before", {31'd0, db_out[0]}, 32'd0);
      cycles(1);
      chk("t1_db_rise",   {31'd0, db_out[0]}, 32'd1);
      chk("t1_rise",      {31'd0, rise[0]},   32'd1);
      chk("t1_press",     {31'd0, press[0]},  32'd1);
      cycles(1);
      chk("t1_rise_1cyc", {31'd0, rise[0]},   32'd0);
      cycles(12);
      raw_in[0] = 1'b0;
      cycles(5);
      chk("t1_fall_before", {31'd0, fall[0]}, 32'd0);
      cycles(1);
      chk("t1_fall",      {31'd0, fall[0]},   32'd1);
      chk("t1_db_fall",   {31'd0, db_out[0]}, 32'd0);

      // 2: bounce on ch2
      raw_in[2] = 1'b1; cycles(2);
      raw_in[2] = 1'b0; cycles(2);
      raw_in[2] = 1'b1; cycles(2);
      raw_in[2] = 1'b0; cycles(2);
      raw_in[2] = 1'b1;
      cycles(5);
      chk("t2_db_held",   {31'd0, db_out[2]}, 32'd0);
      cycles(1);
      chk("t2_db_rise",   {31'd0, db_out[2]}, 32'd1);
      chk("t2_rise",      {31'd0, rise[2]},   32'd1);

      // 3: auto-repeat on ch1, release so the fall lands on a repeat slot
      raw_in[1] = 1'b1;
      cycles(6);
      chk("t3_press_R",   {31'd0, press[1]}, 32'd1);
      chk("t3_rise_R",    {31'd0, rise[1]},  32'd1);
      cycles(9);
      chk("t3_press_R9",  {31'd0, press[1]}, 32'd0);
      cycles(1);
      chk("t3_press_R10", {31'd0, press[1]}, 32'd1);
      cycles(3);
      chk("t3_press_R13", {31'd0, press[1]}, 32'd1);
      cycles(3);
      chk("t3_press_R16", {31'd0, press[1]}, 32'd1);
      cycles(15);
      chk("t3_press_R31", {31'd0, press[1]}, 32'd1);
      raw_in[1] = 1'b0;
      cycles(6);
      chk("t3_fall_R37",  {31'd0, fall[1]},  32'd1);
      chk("t3_press_R37", {31'd0, press[1]}, 32'd0);
      cycles(12);
      chk("t3_db_low",    {31'd0, db_out[1]}, 32'd0);

      // 4: simultaneous rise on all non-repeat channels
      raw_in = 8'h00;
      cycles(10);
      chk("t4_db_zero", {24'd0, db_out}, 32'd0);
      raw_in = 8'hFD;
      cycles(5);
      chk("t4_rise_before", {24'd0, rise}, 32'd0);
      cycles(1);
      chk("t4_rise",  {24'd0, rise},   32'h0000_00FD);
      chk("t4_fall",  {24'd0, fall},   32'd0);
      chk("t4_press", {24'd0, press},  32'h0000_00FD);
      chk("t4_db",    {24'd0, db_out}, 32'h0000_00FD);

      // 5: reset two cycles into a pending rise on ch3
      raw_in = 8'hF5;
      cycles(10);
      chk("t5_db_f5", {24'd0, db_out}, 32'h0000_00F5);
      raw_in = 8'hFD;
      cycles(4);
      rst = 1'b1;
      #1;
      chk("t5_reset_outputs", {db_out, rise, fall, press}, 32'd0);
      cycles(2);
      rst = 1'b0;
      cycles(5);
      chk("t5_rise_before", {24'd0, rise},   32'd0);
      chk("t5_db_before",   {24'd0, db_out}, 32'd0);
      cycles(1);
      chk("t5_rise", {24'd0, rise},   32'h0000_00FD);
      chk("t5_db",   {24'd0, db_out}, 32'h0000_00FD);
      cycles(5);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
